// File: rtl/relobi_xbar_sel_guard.sv
// Select guard for one reliable-OBI crossbar stage: replicated ECC and address
// decode, manager-index vote, in-order target lock and fault accounting.

package hsiao_ecc_pkg;
  // Fewest check bits giving single-error-correct / double-error-detect.
  function automatic int unsigned min_ecc(input int unsigned data_width);
    int unsigned r;
    r = 32;
    for (int k = 31; k >= 2; k--) begin
      if ((64'd1 << (k - 1)) >= 64'(data_width + 32'(k))) r = 32'(k);
    end
    return r;
  endfunction
endpackage

package relobi_sel_guard_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;
endpackage

module relobi_xbar_sel_guard #(
  parameter int unsigned NumSbrPorts   = 4,
  parameter int unsigned NumMgrPorts   = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned EccAddrWidth  = AddrWidth + hsiao_ecc_pkg::min_ecc(AddrWidth),
  parameter int unsigned NumAddrRules  = 4,
  parameter type         addr_map_rule_t = relobi_sel_guard_pkg::addr_rule_t,
  parameter int unsigned NumReplicas   = 3,
  parameter int unsigned NumMaxTrans   = 4,
  parameter int unsigned FaultCntWidth = 8,
  parameter bit          DecodeAbort   = 1'b1,
  parameter int unsigned IdxWidth      = (NumMgrPorts > 1) ? $clog2(NumMgrPorts) : 1
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  addr_map_rule_t [NumReplicas-1:0][NumAddrRules-1:0]    addr_map_i,
  input  logic [NumReplicas-1:0][NumSbrPorts-1:0]               en_default_idx_i,
  input  logic [NumReplicas-1:0][NumSbrPorts-1:0][IdxWidth-1:0] default_idx_i,
  input  logic [NumSbrPorts-1:0]                                sbr_req_i,
  input  logic [NumSbrPorts-1:0][EccAddrWidth-1:0]              sbr_addr_i,
  output logic [NumSbrPorts-1:0]                                sbr_gnt_o,
  input  logic [NumSbrPorts-1:0]                                sbr_rsp_done_i,
  output logic [NumSbrPorts-1:0]                                mgr_req_o,
  input  logic [NumSbrPorts-1:0]                                mgr_gnt_i,
  output logic [NumSbrPorts-1:0][IdxWidth-1:0]                  mgr_sel_o,
  output logic [NumSbrPorts-1:0]                                abort_o,
  output logic [NumSbrPorts-1:0][FaultCntWidth-1:0]             fault_cnt_o,
  input  logic                                                  fault_clr_i,
  output logic [1:0]                                            fault_o
);

  localparam int unsigned EccBits  = EccAddrWidth - AddrWidth;
  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [IdxWidth-1:0]  idx_t;
  typedef logic [EccBits-1:0]   syn_t;
  typedef logic [CntWidth-1:0]  cnt_t;

  // Data column i is the i-th odd-weight (>=3) vector in ascending order; check
  // bits own the weight-1 columns, so odd syndromes mark single-bit errors.
  function automatic logic [AddrWidth-1:0][EccBits-1:0] gen_cols();
    logic [AddrWidth-1:0][EccBits-1:0] cols;
    syn_t v;
    cols = '0;
    v    = '0;
    for (int i = 0; i < AddrWidth; i++) begin
      do v = v + syn_t'(1); while (!($countones(v) >= 3 && ($countones(v) % 2) == 1));
      cols[i] = v;
    end
    return cols;
  endfunction

  localparam logic [AddrWidth-1:0][EccBits-1:0] HCols = gen_cols();

  function automatic syn_t ecc_syndrome(input logic [EccAddrWidth-1:0] cw);
    syn_t s;
    s = cw[EccAddrWidth-1:AddrWidth];
    for (int i = 0; i < AddrWidth; i++) begin
      if (cw[i]) s = s ^ HCols[i];
    end
    return s;
  endfunction

  function automatic addr_t ecc_correct(input logic [EccAddrWidth-1:0] cw, input syn_t s);
    addr_t d;
    d = cw[AddrWidth-1:0];
    for (int i = 0; i < AddrWidth; i++) begin
      if (s == HCols[i]) d[i] = ~d[i];
    end
    return d;
  endfunction

  // Last matching rule wins; no match falls back to the (optional) default.
  function automatic idx_t decode_addr(input addr_t addr,
                                       input addr_map_rule_t [NumAddrRules-1:0] rules,
                                       input logic en_def, input idx_t def_idx);
    idx_t idx;
    idx = en_def ? def_idx : '0;
    for (int k = 0; k < NumAddrRules; k++) begin
      if (addr >= addr_t'(rules[k].start_addr) && addr < addr_t'(rules[k].end_addr))
        idx = idx_t'(rules[k].idx);
    end
    return idx;
  endfunction

  syn_t [NumSbrPorts-1:0][NumReplicas-1:0] rep_syn;
  idx_t [NumSbrPorts-1:0][NumReplicas-1:0] rep_idx;
  logic [NumSbrPorts-1:0][NumReplicas-1:0] rep_corr, rep_unc;

  always_comb begin
    rep_syn  = '0;
    rep_idx  = '0;
    rep_corr = '0;
    rep_unc  = '0;
    for (int p = 0; p < NumSbrPorts; p++) begin
      for (int r = 0; r < NumReplicas; r++) begin
        rep_syn[p][r]  = ecc_syndrome(sbr_addr_i[p]);
        rep_corr[p][r] = (rep_syn[p][r] != '0) && (^rep_syn[p][r]);
        rep_unc[p][r]  = (rep_syn[p][r] != '0) && !(^rep_syn[p][r]);
        rep_idx[p][r]  = decode_addr(DecodeAbort ? sbr_addr_i[p][AddrWidth-1:0]
                                                 : ecc_correct(sbr_addr_i[p], rep_syn[p][r]),
                                     addr_map_i[r], en_default_idx_i[r][p],
                                     default_idx_i[r][p]);
      end
    end
  end

  idx_t [NumSbrPorts-1:0] sel;
  logic [NumSbrPorts-1:0] unc_vote, mismatch;

  if (NumReplicas == 3) begin : g_tmr
    always_comb begin
      sel      = '0;
      unc_vote = '0;
      mismatch = '0;
      for (int p = 0; p < NumSbrPorts; p++) begin
        sel[p] = (rep_idx[p][0] & rep_idx[p][1]) | (rep_idx[p][0] & rep_idx[p][2]) |
                 (rep_idx[p][1] & rep_idx[p][2]);
        unc_vote[p] = (rep_unc[p][0] & rep_unc[p][1]) | (rep_unc[p][0] & rep_unc[p][2]) |
                      (rep_unc[p][1] & rep_unc[p][2]);
        mismatch[p] = (rep_idx[p][0] != rep_idx[p][1]) || (rep_idx[p][0] != rep_idx[p][2]) ||
                      (rep_unc[p][0] != rep_unc[p][1]) || (rep_unc[p][0] != rep_unc[p][2]);
      end
    end
  end else begin : g_single
    always_comb begin
      sel      = '0;
      unc_vote = '0;
      mismatch = '0;
      for (int p = 0; p < NumSbrPorts; p++) begin
        sel[p]      = rep_idx[p][0];
        unc_vote[p] = rep_unc[p][0];
      end
    end
  end

  cnt_t [NumSbrPorts-1:0]                    cnt_q;
  idx_t [NumSbrPorts-1:0]                    lock_sel_q;
  logic [NumSbrPorts-1:0]                    lock_abort_q;
  logic [NumSbrPorts-1:0][FaultCntWidth-1:0] fault_cnt_q;
  logic [1:0]                                fault_q;

  logic [NumSbrPorts-1:0] abort_cond, allow, hs, fault_any, underflow;
  logic                   corr_hit, unc_hit;

  always_comb begin
    abort_cond = '0;
    allow      = '0;
    hs         = '0;
    fault_any  = '0;
    underflow  = '0;
    mgr_req_o  = '0;
    sbr_gnt_o  = '0;
    abort_o    = '0;
    corr_hit   = 1'b0;
    unc_hit    = 1'b0;
    for (int p = 0; p < NumSbrPorts; p++) begin
      abort_cond[p] = DecodeAbort && unc_vote[p];
      // Same target and same abort kind may pile up; anything else waits for drain.
      allow[p] = (cnt_q[p] == '0) ||
                 ((cnt_q[p] < cnt_t'(NumMaxTrans)) && (sel[p] == lock_sel_q[p]) &&
                  (abort_cond[p] == lock_abort_q[p]));
      mgr_req_o[p] = sbr_req_i[p] && allow[p] && !abort_cond[p];
      abort_o[p]   = sbr_req_i[p] && allow[p] && abort_cond[p];
      sbr_gnt_o[p] = sbr_req_i[p] && allow[p] && (abort_cond[p] || mgr_gnt_i[p]);
      hs[p]        = sbr_gnt_o[p];
      fault_any[p] = (|rep_corr[p]) || (|rep_unc[p]) || mismatch[p];
      underflow[p] = sbr_rsp_done_i[p] && (cnt_q[p] == '0);
      corr_hit     = corr_hit || (hs[p] && (|rep_corr[p]));
      unc_hit      = unc_hit || (hs[p] && ((|rep_unc[p]) || mismatch[p])) || underflow[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      lock_sel_q   <= '0;
      lock_abort_q <= '0;
      fault_cnt_q  <= '0;
      fault_q      <= '0;
    end else begin
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (hs[p]) begin
          lock_sel_q[p]   <= sel[p];
          lock_abort_q[p] <= abort_cond[p];
          if (!(sbr_rsp_done_i[p] && cnt_q[p] != '0)) cnt_q[p] <= cnt_q[p] + cnt_t'(1);
        end else if (sbr_rsp_done_i[p] && cnt_q[p] != '0) begin
          cnt_q[p] <= cnt_q[p] - cnt_t'(1);
        end
      end
      if (fault_clr_i) begin
        fault_cnt_q <= '0;
        fault_q     <= '0;
      end else begin
        for (int p = 0; p < NumSbrPorts; p++) begin
          if (hs[p] && fault_any[p] && (fault_cnt_q[p] != {FaultCntWidth{1'b1}}))
            fault_cnt_q[p] <= fault_cnt_q[p] + FaultCntWidth'(1);
        end
        fault_q <= fault_q | {unc_hit, corr_hit};
      end
    end
  end

  assign mgr_sel_o   = sel;
  assign fault_cnt_o = fault_cnt_q;
  assign fault_o     = fault_q;

endmodule
